fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end for the filter processor. It drives word addresses into the 256 x 16 instruction memory and samples the returned 16-bit instruction words. It tags each word with its address and buffers it in a 2-entry queue, which the decoder drains through a valid/ready handshake. It also handles branch redirects and end-of-program halt detection.

## Interface
- `RESET_PC`, default 0: address fetched first after reset.
- `ADDR_LAST`, default 255: last legal instruction address; fetching it ends the program.
- `HALT_WORD`, default 16'hFFFF: fill/terminator word; sampling it halts fetch.

- `clk` in, 1: single clock; all state changes on rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `o_pc` in→out, 32: word address driven to the instruction memory (its `i_dir`).
- `i_inst` in, 16: instruction word from memory. It is updated by memory on the falling edge and sampled here on the rising edge.
- `i_redirect` in, 1: branch/jump redirect strobe.
- `i_target` in, 32: redirect target address, valid with `i_redirect`.
- `o_valid` out, 1: queue head holds an instruction.
- `i_ready` in, 1: decoder accepts the head this cycle.
- `o_inst` out, 16: head instruction.
- `o_inst_pc` out, 32: address of the head instruction.
- `o_halted` out, 1: fetch stopped (terminator or `ADDR_LAST` reached).
- `o_fetch_count` out, 16: instructions pushed (see Configuration).
- `o_stall_count` out, 16: cycles lost to a full queue (see Configuration).

## Operation
- States: WARMUP, RUN, HALT.
- Reset (async) puts the block in WARMUP with `o_pc`=`RESET_PC`, queue empty, and `o_valid`=0. `o_inst`=0, `o_inst_pc`=0, `o_halted`=0, and both counters are 0.
- WARMUP lasts exactly one rising edge. `i_inst` is discarded and `o_pc` is held; this covers the memory's first-falling-edge initialisation. The block then goes to RUN.
- RUN: each rising edge samples `i_inst` as the word for the current `o_pc`. The word is accepted when the queue has room, meaning count<2 or a pop occurs on the same edge. Possible outcomes:
  - Accepted and `i_inst`==`HALT_WORD`: the word is not pushed, `o_pc` is held, and the state goes to HALT.
  - Accepted and `o_pc`==`ADDR_LAST`: the word is pushed, `o_pc` is held, and the state goes to HALT. `HALT_WORD` takes priority over this case.
  - Accepted otherwise: push {`i_inst`, `o_pc`} and set `o_pc`←`o_pc`+1. The increment is 32-bit unsigned, and no wrap is reachable.
  - Not accepted: `o_pc` is held, and the same address is re-sampled next edge.
- HALT: no sampling and no pushes. The queue keeps draining and `o_halted`=1.
- Pop: `o_valid`&&`i_ready` removes the head. `o_inst`/`o_inst_pc` show the next entry, or hold their last value when empty.
- Redirect (`i_redirect`=1) takes priority over all other events in any state except WARMUP, where it is ignored. Effects on the same edge:
  - Any same-edge handshake counts as consumed.
  - The whole queue is flushed and the sampled `i_inst` is discarded.
  - `o_pc`←`i_target`, `o_halted`←0, and the state goes to RUN.
- A redirect to a target greater than `ADDR_LAST` fetches one word, pushes it, and halts.

## Timing
- Memory round trip is half a cycle. `o_pc` changes at rising edge t, memory reads at the falling edge, and the word is sampled at edge t+1. With the queue not full, throughput is 1 instruction/cycle.
- `o_valid` rises at the edge following the push.
- The first `o_valid` after reset release comes at the 2nd rising edge: one edge of WARMUP, then one edge of capture.
- Redirect-to-first-valid latency is 2 edges: the redirect edge, then the capture edge.
- Full queue with `i_ready`=0 gives 0 pushes. Full queue with `i_ready`=1 gives push and pop on the same edge, so count stays 2.
- Reset asserted mid-operation clears everything immediately (async), with no partial pop or push.

## Configuration
- `FETCH_STATS_EN` defined:
  - `o_fetch_count` increments per push.
  - `o_stall_count` increments per RUN edge on which a word is not accepted.
  - Both counters saturate at 16'hFFFF, are cleared by reset, and are not cleared by redirect.
- `FETCH_STATS_EN` undefined: both outputs are tied to 0 and no counter logic is built.

## Test plan
- Memory 0..3 = B300, B200, B100, FFFF, `i_ready`=1: the decoder sees (B300,0), (B200,1), (B100,2) on consecutive cycles, then `o_halted`=1 with `o_pc`=3. With stats enabled, `o_fetch_count`=3.
- `i_ready`=0 for 5 cycles after start: queue holds (B300,0), (B200,1) and `o_pc`=2 stays constant. `o_stall_count`=4, and 3 words then drain in order once `i_ready`=1.
- `i_redirect` with `i_target`=7 while queue holds 2 entries: queue is empty the next cycle, and the next `o_valid` shows (mem[7],7) 2 edges later.
- Redirect in HALT with target 0: `o_halted`→0 and fetch restarts with (B300,0).
- No terminator, `i_ready`=1: word at 255 is delivered with `o_inst_pc`=255, then `o_halted`=1 and `o_pc`=255.
- `rst` pulsed mid-stream with queue full: `o_valid`=0, `o_pc`=0 and counters=0 immediately. After release, the first word appears at the 2nd edge.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end with a 2-entry tagged queue, redirect and halt detection.
// Optional FETCH_STATS_EN builds the saturating fetch/stall counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] ADDR_LAST = 32'd255,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] o_pc,
  input  logic [15:0] i_inst,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_halted,
  output logic [15:0] o_fetch_count,
  output logic [15:0] o_stall_count
);

  typedef enum logic [1:0] {WARMUP, RUN, HALT} state_t;

  state_t      state;
  logic [1:0]  count;
  logic [15:0] q1_inst;
  logic [31:0] q1_pc;

  logic pop, accept, halt_hit, push;

  always_comb begin
    pop      = (count != 2'd0) && i_ready;
    accept   = (state == RUN) && !i_redirect && ((count < 2'd2) || pop);
    halt_hit = accept && (i_inst == HALT_WORD);
    push     = accept && !halt_hit;
  end

  assign o_valid = (count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= WARMUP;
      o_pc      <= RESET_PC;
      count     <= 2'd0;
      o_inst    <= 16'd0;
      o_inst_pc <= 32'd0;
      q1_inst   <= 16'd0;
      q1_pc     <= 32'd0;
      o_halted  <= 1'b0;
    end else begin
      case (state)
        WARMUP: state <= RUN;
        default: begin
          if (i_redirect) begin
            // Flush keeps the head registers so o_inst/o_inst_pc hold while empty.
            count    <= 2'd0;
            o_pc     <= i_target;
            o_halted <= 1'b0;
            state    <= RUN;
          end else begin
            case ({push, pop})
              2'b10: begin
                if (count == 2'd0) begin
                  o_inst    <= i_inst;
                  o_inst_pc <= o_pc;
                  count     <= 2'd1;
                end else begin
                  q1_inst <= i_inst;
                  q1_pc   <= o_pc;
                  count   <= 2'd2;
                end
              end
              2'b01: begin
                if (count == 2'd2) begin
                  o_inst    <= q1_inst;
                  o_inst_pc <= q1_pc;
                end
                count <= count - 2'd1;
              end
              2'b11: begin
                if (count == 2'd1) begin
                  o_inst    <= i_inst;
                  o_inst_pc <= o_pc;
                end else begin
                  o_inst    <= q1_inst;
                  o_inst_pc <= q1_pc;
                  q1_inst   <= i_inst;
                  q1_pc     <= o_pc;
                end
              end
              default: ;
            endcase

            if (halt_hit) begin
              state    <= HALT;
              o_halted <= 1'b1;
            end else if (push) begin
              // Targets beyond the last address still deliver one word before halting.
              if (o_pc >= ADDR_LAST) begin
                state    <= HALT;
                o_halted <= 1'b1;
              end else begin
                o_pc <= o_pc + 32'd1;
              end
            end
          end
        end
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic        stall;
  logic [15:0] fetch_cnt, stall_cnt;

  assign stall = (state == RUN) && !i_redirect && !accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (push && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_fetch_count = fetch_cnt;
  assign o_stall_count = stall_cnt;
`else
  assign o_fetch_count = 16'd0;
  assign o_stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit with a half-cycle memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] o_pc;
  logic [15:0] i_inst = 16'd0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_target = 32'd0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_halted;
  logic [15:0] o_fetch_count;
  logic [15:0] o_stall_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:255];

  fetch_unit dut (
    .clk(clk), .rst(rst), .o_pc(o_pc), .i_inst(i_inst),
    .i_redirect(i_redirect), .i_target(i_target), .o_valid(o_valid),
    .i_ready(i_ready), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .o_halted(o_halted), .o_fetch_count(o_fetch_count), .o_stall_count(o_stall_count)
  );

  always #5 clk = ~clk;

  // Memory answers on the falling edge for the address presented.
  always @(negedge clk) begin
    if (o_pc < 32'd256) i_inst = mem[o_pc[7:0]];
    else i_inst = 16'h3333;
  end

  typedef struct {
    bit          do_rst;
    bit          ready;
    bit          redir;
    logic [31:0] target;
    bit          v;
    logic [15:0] inst;
    logic [31:0] ipc;
    bit          halted;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] stat(input int v);
`ifdef FETCH_STATS_EN
    return v[15:0];
`else
    return (v != 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    i_redirect = 1'b0;
    #1;
    check("rst valid", o_valid, 0);
    check("rst pc", o_pc, 0);
    check("rst inst", o_inst, 0);
    check("rst inst_pc", o_inst_pc, 0);
    check("rst halted", o_halted, 0);
    check("rst fetch_count", o_fetch_count, 0);
    check("rst stall_count", o_stall_count, 0);
    step();
    rst = 1'b0;
  endtask

  function automatic void add(input bit r, input bit rdy, input bit rd, input logic [31:0] t,
                              input bit v, input logic [15:0] in, input logic [31:0] ip,
                              input bit h, input logic [31:0] pc);
    vec_t e;
    e.do_rst = r; e.ready = rdy; e.redir = rd; e.target = t;
    e.v = v; e.inst = in; e.ipc = ip; e.halted = h; e.pc = pc;
    vecs.push_back(e);
  endfunction

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) reset_dut();
      i_ready    = vecs[i].ready;
      i_redirect = vecs[i].redir;
      i_target   = vecs[i].target;
      step();
      check($sformatf("%s row%0d valid", tag, i), o_valid, vecs[i].v);
      check($sformatf("%s row%0d inst", tag, i), o_inst, vecs[i].inst);
      check($sformatf("%s row%0d inst_pc", tag, i), o_inst_pc, vecs[i].ipc);
      check($sformatf("%s row%0d halted", tag, i), o_halted, vecs[i].halted);
      check($sformatf("%s row%0d pc", tag, i), o_pc, vecs[i].pc);
    end
    i_redirect = 1'b0;
    vecs.delete();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'hB300; mem[1] = 16'hB200; mem[2] = 16'hB100; mem[3] = 16'hFFFF;

    // Straight run to the terminator.
    add(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 0, 1, 16'hB300, 0, 0, 1);
    add(0, 1, 0, 0, 1, 16'hB200, 1, 0, 2);
    add(0, 1, 0, 0, 1, 16'hB100, 2, 0, 3);
    add(0, 1, 0, 0, 0, 16'hB100, 2, 1, 3);
    add(0, 1, 0, 0, 0, 16'hB100, 2, 1, 3);
    run_vecs("run");
    check("run fetch_count", o_fetch_count, stat(3));
    check("run stall_count", o_stall_count, stat(0));

    // Back-pressure: queue fills, pc holds, then drains with push+pop at full.
    add(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 0, 0, 0, 1, 16'hB300, 0, 0, 1);
    for (int k = 3; k <= 7; k++) add(0, 0, 0, 0, 1, 16'hB300, 0, 0, 2);
    add(0, 1, 0, 0, 1, 16'hB200, 1, 0, 3);
    add(0, 1, 0, 0, 1, 16'hB100, 2, 1, 3);
    add(0, 1, 0, 0, 0, 16'hB100, 2, 1, 3);
    run_vecs("stall");
    check("stall stall_count", o_stall_count, stat(4));
    check("stall fetch_count", o_fetch_count, stat(3));

    // Redirects: flush of full queue, beyond-last target, restart from HALT.
    add(1, 0, 0, 0,   0, 16'h0000, 0,   0, 0);
    add(0, 0, 0, 0,   1, 16'hB300, 0,   0, 1);
    add(0, 0, 0, 0,   1, 16'hB300, 0,   0, 2);
    add(0, 0, 1, 7,   0, 16'hB300, 0,   0, 7);
    add(0, 1, 0, 0,   1, 16'h1007, 7,   0, 8);
    add(0, 1, 0, 0,   1, 16'h1008, 8,   0, 9);
    add(0, 1, 1, 300, 0, 16'h1008, 8,   0, 300);
    add(0, 1, 0, 0,   1, 16'h3333, 300, 1, 300);
    add(0, 1, 0, 0,   0, 16'h3333, 300, 1, 300);
    add(0, 1, 1, 0,   0, 16'h3333, 300, 0, 0);
    add(0, 1, 0, 0,   1, 16'hB300, 0,   0, 1);
    add(0, 1, 0, 0,   1, 16'hB200, 1,   0, 2);
    run_vecs("redir");
    check("redir fetch_count", o_fetch_count, stat(7));
    check("redir stall_count", o_stall_count, stat(0));

    // No terminator: run to ADDR_LAST.
    mem[3] = 16'hB000;
    reset_dut();
    i_ready = 1'b1;
    step();
    for (int k = 2; k <= 257; k++) begin
      step();
      check($sformatf("last e%0d valid", k), o_valid, 1);
      check($sformatf("last e%0d inst_pc", k), o_inst_pc, 32'(k - 2));
      check($sformatf("last e%0d inst", k), o_inst, mem[k - 2]);
      check($sformatf("last e%0d pc", k), o_pc, (k == 257) ? 32'd255 : 32'(k - 1));
      check($sformatf("last e%0d halted", k), o_halted, (k == 257) ? 1 : 0);
    end
    step();
    check("last drained valid", o_valid, 0);
    check("last drained halted", o_halted, 1);
    check("last drained pc", o_pc, 255);
    check("last fetch_count", o_fetch_count, stat(256));

    // Async reset with a full queue.
    mem[3] = 16'hFFFF;
    reset_dut();
    i_ready = 1'b0;
    step(); step(); step();
    check("midrst pre valid", o_valid, 1);
    check("midrst pre fetch_count", o_fetch_count, stat(2));
    #2;
    rst = 1'b1;
    #1;
    check("midrst valid", o_valid, 0);
    check("midrst pc", o_pc, 0);
    check("midrst halted", o_halted, 0);
    check("midrst fetch_count", o_fetch_count, 0);
    check("midrst stall_count", o_stall_count, 0);
    step();
    rst = 1'b0;
    i_ready = 1'b1;
    step();
    check("midrst e1 valid", o_valid, 0);
    step();
    check("midrst e2 valid", o_valid, 1);
    check("midrst e2 inst", o_inst, 16'hB300);
    check("midrst e2 inst_pc", o_inst_pc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
